// File: rtl/branch_predict_unit_pkg.sv
// Shared branch definitions: funct3 condition encodings and the condition evaluator.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
package branch_predict_unit_pkg;

  // funct3 encodings of the conditional branches (shared with decoder and ALU)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch condition from ALU flags; lt is already signed/unsigned per funct3.
  // Reserved encodings 010/011 never take.
  function automatic logic cond_eval(input logic [2:0] f3, input logic z, input logic lt);
    logic c;
    case (f3)
      F3_BEQ:  c = z;
      F3_BNE:  c = ~z;
      F3_BLT:  c = lt;
      F3_BGE:  c = ~lt;
      F3_BLTU: c = lt;
      F3_BGEU: c = ~lt;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Resolves branch taken/not-taken from BranchEn/IsUncond/funct3/z/lt; drop-in for the legacy unit.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module branch_cond
  import branch_predict_unit_pkg::*;
(
  input  logic       BranchEn,
  input  logic       IsUncond,
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       lt,
  output logic       Branch
);

  // A non-branch never takes; a jump always takes; otherwise the funct3 condition decides
  assign Branch = BranchEn & (IsUncond | cond_eval(funct3, z, lt));

endmodule

// File: rtl/branch_predict_unit.sv
// Saturating-counter branch predictor (optional gshare) with registered mispredict/redirect and perf counters.
// Latency: prediction 0 cycles; table/GHR update, Mispredict/RedirectPC and counters visible 1 cycle after resolve.
// Backpressure: none; one predict and one resolve accepted every cycle.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IDX_BITS  = 6,
  parameter int CTR_BITS  = 2,
  parameter int GSHARE    = 0,
  parameter int PERF_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 PredValid,
  input  logic [XLEN-1:0]      PredPC,
  output logic                 PredTaken,
  output logic [IDX_BITS-1:0]  PredIdx,
  input  logic                 ResValid,
  input  logic [IDX_BITS-1:0]  ResIdx,
  input  logic                 ResPredTkn,
  input  logic [XLEN-1:0]      ResTarget,
  input  logic [XLEN-1:0]      ResPCPlus4,
  input  logic                 BranchEn,
  input  logic                 IsUncond,
  input  logic [2:0]           funct3,
  input  logic                 z,
  input  logic                 lt,
  output logic                 Branch,
  output logic                 Mispredict,
  output logic [XLEN-1:0]      RedirectPC,
  output logic [PERF_BITS-1:0] BrCount,
  output logic [PERF_BITS-1:0] MissCount
);

  localparam int DEPTH = 1 << IDX_BITS;
  // Weakly not-taken: MSB clear, all lower bits set
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [PERF_BITS-1:0] PERF_MAX = '1;

  logic [CTR_BITS-1:0]  ctr_q [DEPTH];
  logic [CTR_BITS-1:0]  ctr_cur;
  logic [CTR_BITS-1:0]  ctr_d;
  logic [IDX_BITS-1:0]  ghr_q, ghr_d;
  logic                 mispredict_q, mispredict_d;
  logic [XLEN-1:0]      redirect_q, redirect_d;
  logic [PERF_BITS-1:0] br_cnt_q, br_cnt_d;
  logic [PERF_BITS-1:0] miss_cnt_q, miss_cnt_d;
  logic                 branch;
  logic                 upd;
  logic                 miss;
  logic [IDX_BITS-1:0]  pred_idx;
  logic                 unused_pc;

  branch_cond u_branch_cond (
    .BranchEn (BranchEn),
    .IsUncond (IsUncond),
    .funct3   (funct3),
    .z        (z),
    .lt       (lt),
    .Branch   (branch)
  );

  // Word-aligned PC bits select the entry; upper PC bits and the byte offset do not index the table
  assign unused_pc = ^{PredPC[XLEN-1:IDX_BITS+2], PredPC[1:0]};
  assign pred_idx  = PredPC[IDX_BITS+1:2] ^ ((GSHARE != 0) ? ghr_q : '0);

  // Read is from the registered table, so a same-cycle update to this entry shows up next cycle
  assign PredIdx    = pred_idx;
  assign PredTaken  = PredValid & ctr_q[pred_idx][CTR_BITS-1];
  assign Branch     = branch;
  assign Mispredict = mispredict_q;
  assign RedirectPC = redirect_q;
  assign BrCount    = br_cnt_q;
  assign MissCount  = miss_cnt_q;

  // Next-state: counter training, history shift, mispredict detection and saturating perf counters
  always_comb begin
    upd        = ResValid & BranchEn & ~IsUncond;
    // A non-branch that IF predicted taken steered fetch away from the fall-through path
    miss       = ResValid & (BranchEn ? (branch != ResPredTkn) : ResPredTkn);
    ctr_cur    = ctr_q[ResIdx];
    ctr_d      = ctr_cur;
    ghr_d      = ghr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    redirect_d = redirect_q;

    if (branch) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_BITS'(1);
    end

    if (upd) begin
      if (GSHARE != 0) ghr_d = {ghr_q[IDX_BITS-2:0], branch};
      if (br_cnt_q != PERF_MAX) br_cnt_d = br_cnt_q + PERF_BITS'(1);
    end

    mispredict_d = miss;
    if (miss) begin
      // branch is 0 for non-branches, so they redirect to the fall-through PC
      redirect_d = branch ? ResTarget : ResPCPlus4;
      if (miss_cnt_q != PERF_MAX) miss_cnt_d = miss_cnt_q + PERF_BITS'(1);
    end
  end

  // Counter table: reset to weakly not-taken, write back the trained entry on conditional resolves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd) begin
      ctr_q[ResIdx] <= ctr_d;
    end
  end

  // History, mispredict pulse, redirect target and performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: bimodal (GSHARE=0) and gshare (GSHARE=1) instances side by side.
// Latency: checks combinational outputs mid-cycle and registered outputs 1 time unit after each rising edge.
// Backpressure: none; stimulus applied every cycle.
module tb_branch_predict_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        PredValid, ResValid, ResPredTkn, BranchEn, IsUncond, z, lt;
  logic [31:0] PredPC, ResTarget, ResPCPlus4;
  logic [5:0]  ResIdx;
  logic [2:0]  funct3;

  logic        PredTaken_a, Branch_a, Mispredict_a;
  logic [5:0]  PredIdx_a;
  logic [31:0] RedirectPC_a;
  logic [15:0] BrCount_a, MissCount_a;
  logic        PredTaken_g, Branch_g, Mispredict_g;
  logic [5:0]  PredIdx_g;
  logic [31:0] RedirectPC_g;
  logic [15:0] BrCount_g, MissCount_g;

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CTR_BITS(2), .GSHARE(0), .PERF_BITS(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .PredValid(PredValid), .PredPC(PredPC),
    .PredTaken(PredTaken_a), .PredIdx(PredIdx_a), .ResValid(ResValid), .ResIdx(ResIdx),
    .ResPredTkn(ResPredTkn), .ResTarget(ResTarget), .ResPCPlus4(ResPCPlus4),
    .BranchEn(BranchEn), .IsUncond(IsUncond), .funct3(funct3), .z(z), .lt(lt),
    .Branch(Branch_a), .Mispredict(Mispredict_a), .RedirectPC(RedirectPC_a),
    .BrCount(BrCount_a), .MissCount(MissCount_a)
  );

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CTR_BITS(2), .GSHARE(1), .PERF_BITS(16)) u_gs (
    .clk(clk), .reset_n(reset_n), .PredValid(PredValid), .PredPC(PredPC),
    .PredTaken(PredTaken_g), .PredIdx(PredIdx_g), .ResValid(ResValid), .ResIdx(ResIdx),
    .ResPredTkn(ResPredTkn), .ResTarget(ResTarget), .ResPCPlus4(ResPCPlus4),
    .BranchEn(BranchEn), .IsUncond(IsUncond), .funct3(funct3), .z(z), .lt(lt),
    .Branch(Branch_g), .Mispredict(Mispredict_g), .RedirectPC(RedirectPC_g),
    .BrCount(BrCount_g), .MissCount(MissCount_g)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic       en;
    logic       unc;
    logic       zz;
    logic       ll;
    logic [2:0] f3;
    logic       exp;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: both instances see identical ResIdx streams, so one table model serves both
  int          ma[64];
  int          mbr, mmiss;
  logic [31:0] mred;
  logic [5:0]  mghr;

  task automatic push(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0h", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
      end
    end
  endtask

  function automatic logic exp_branch(input logic en, input logic unc, input logic [2:0] f3,
                                      input logic zz, input logic ll);
    logic c;
    case (f3)
      3'b000:         c = zz;
      3'b001:         c = !zz;
      3'b100, 3'b110: c = ll;
      3'b101, 3'b111: c = !ll;
      default:        c = 1'b0;
    endcase
    return en & (unc | c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ma[i] = 1;
    mbr   = 0;
    mmiss = 0;
    mred  = '0;
    mghr  = '0;
  endtask

  task automatic idle();
    PredValid  = 1'b0; PredPC     = '0;
    ResValid   = 1'b0; ResIdx     = '0; ResPredTkn = 1'b0;
    ResTarget  = '0;   ResPCPlus4 = '0;
    BranchEn   = 1'b0; IsUncond   = 1'b0; funct3 = 3'b000; z = 1'b0; lt = 1'b0;
  endtask

  // Checks combinational outputs for the driven inputs, advances the model, clocks once,
  // then checks the registered outputs
  task automatic run_cycle(input string tag);
    logic eb, upd, miss;
    int   gi;
    eb = exp_branch(BranchEn, IsUncond, funct3, z, lt);
    gi = int'(PredPC[7:2] ^ mghr);
    #1;
    push({tag, " Branch"},      32'(eb));                               chk(32'(Branch_a));
    push({tag, " Branch_g"},    32'(eb));                               chk(32'(Branch_g));
    push({tag, " PredIdx"},     32'(PredPC[7:2]));                      chk(32'(PredIdx_a));
    push({tag, " PredIdx_g"},   32'(PredPC[7:2] ^ mghr));               chk(32'(PredIdx_g));
    push({tag, " PredTaken"},   32'(PredValid && ma[PredPC[7:2]] >= 2)); chk(32'(PredTaken_a));
    push({tag, " PredTaken_g"}, 32'(PredValid && ma[gi] >= 2));          chk(32'(PredTaken_g));

    upd  = ResValid & BranchEn & !IsUncond;
    miss = ResValid & (BranchEn ? (eb != ResPredTkn) : ResPredTkn);
    if (upd) begin
      if (eb) begin
        if (ma[ResIdx] < 3) ma[ResIdx] = ma[ResIdx] + 1;
      end else begin
        if (ma[ResIdx] > 0) ma[ResIdx] = ma[ResIdx] - 1;
      end
      mghr = {mghr[4:0], eb};
      if (mbr < 65535) mbr++;
    end
    if (miss) begin
      mred = eb ? ResTarget : ResPCPlus4;
      if (mmiss < 65535) mmiss++;
    end
    push({tag, " Mispredict"},   32'(miss));
    push({tag, " RedirectPC"},   mred);
    push({tag, " BrCount"},      32'(mbr));
    push({tag, " MissCount"},    32'(mmiss));
    push({tag, " Mispredict_g"}, 32'(miss));
    push({tag, " BrCount_g"},    32'(mbr));
    @(posedge clk);
    #1;
    chk(32'(Mispredict_a));
    chk(RedirectPC_a);
    chk(32'(BrCount_a));
    chk(32'(MissCount_a));
    chk(32'(Mispredict_g));
    chk(32'(BrCount_g));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  vec_t vt[10];
  logic gs_out[3];

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1};
    gs_out[0] = 1'b1; gs_out[1] = 1'b0; gs_out[2] = 1'b1;

    idle();
    reset_n = 1'b0;
    model_reset();
    PredValid = 1'b1;
    PredPC    = 32'h40;
    #12;
    push("rst Mispredict", 32'h0); chk(32'(Mispredict_a));
    push("rst RedirectPC", 32'h0); chk(RedirectPC_a);
    push("rst BrCount",    32'h0); chk(32'(BrCount_a));
    push("rst MissCount",  32'h0); chk(32'(MissCount_a));
    push("rst PredTaken",  32'h0); chk(32'(PredTaken_a));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Predict at 0x40 from a fresh table
    run_cycle("pred40");
    push("pred40 PredIdx literal", 32'd16); chk(32'(PredIdx_a));

    // Four taken BEQs on entry 16: 01->10->11->11, only the first mispredicts
    for (int k = 0; k < 4; k++) begin
      PredValid = 1'b1; PredPC = 32'h40;
      ResValid = 1'b1; BranchEn = 1'b1; IsUncond = 1'b0; funct3 = 3'b000; z = 1'b1; lt = 1'b0;
      ResIdx = 6'd16; ResPredTkn = (k != 0); ResTarget = 32'h1000 + 32'(k); ResPCPlus4 = 32'h44;
      run_cycle("beq16");
      push("beq16 PredTaken after update", 32'h1); chk(32'(PredTaken_a));
    end

    // Legacy condition vectors with ResValid=0: Branch only, no state change
    idle();
    for (int i = 0; i < 10; i++) begin
      BranchEn = vt[i].en; IsUncond = vt[i].unc; z = vt[i].zz; lt = vt[i].ll; funct3 = vt[i].f3;
      #1;
      push($sformatf("legacy[%0d]", i), 32'(vt[i].exp)); chk(32'(Branch_a));
      run_cycle("legacy");
    end

    // BNE taken but predicted not-taken: redirect to target, then pulse drops
    idle();
    ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b001; z = 1'b0; ResPredTkn = 1'b0;
    ResIdx = 6'd20; ResTarget = 32'h100; ResPCPlus4 = 32'h24;
    run_cycle("bne");
    push("bne Mispredict literal", 32'h1);   chk(32'(Mispredict_a));
    push("bne RedirectPC literal", 32'h100); chk(RedirectPC_a);
    idle();
    run_cycle("bne idle");
    push("bne idle Mispredict literal", 32'h0); chk(32'(Mispredict_a));

    // Non-branch predicted taken: redirect to fall-through
    idle();
    ResValid = 1'b1; ResPredTkn = 1'b1; ResTarget = 32'h999; ResPCPlus4 = 32'h204;
    run_cycle("falsetkn");

    // Jump predicted not-taken: mispredicts, no table/count update
    idle();
    PredValid = 1'b1; PredPC = 32'h40;
    ResValid = 1'b1; BranchEn = 1'b1; IsUncond = 1'b1; ResIdx = 6'd16; ResPredTkn = 1'b0;
    ResTarget = 32'h300; ResPCPlus4 = 32'h44;
    run_cycle("jal miss");
    // Jump predicted taken: correct
    ResPredTkn = 1'b1; ResTarget = 32'h340;
    run_cycle("jal hit");

    // BLT not taken but predicted taken: redirect to fall-through, counter 11->10
    idle();
    PredValid = 1'b1; PredPC = 32'h40;
    ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b100; lt = 1'b0; ResIdx = 6'd16;
    ResPredTkn = 1'b1; ResTarget = 32'h800; ResPCPlus4 = 32'h48;
    run_cycle("blt nt");

    // Same-cycle read and write of entry 5
    idle();
    PredValid = 1'b1; PredPC = 32'h14;
    ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b000; z = 1'b1; ResIdx = 6'd5; ResPredTkn = 1'b0;
    ResTarget = 32'h180; ResPCPlus4 = 32'h18;
    #1;
    push("same5 PredTaken before", 32'h0); chk(32'(PredTaken_a));
    run_cycle("same5");
    push("same5 PredTaken after", 32'h1); chk(32'(PredTaken_a));

    // Saturate entry 16 at zero with not-taken BEQs
    for (int k = 0; k < 3; k++) begin
      idle();
      PredValid = 1'b1; PredPC = 32'h40;
      ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b000; z = 1'b0; ResIdx = 6'd16;
      ResPredTkn = (ma[16] >= 2); ResTarget = 32'h600; ResPCPlus4 = 32'h44;
      run_cycle("sat0");
    end
    push("sat0 PredTaken literal", 32'h0); chk(32'(PredTaken_a));

    // Gshare history: taken, not-taken, taken from a clean reset
    idle();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      PredValid = 1'b1; PredPC = 32'h80;
      ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b000; z = gs_out[k];
      ResIdx = 6'h20 ^ mghr; ResPredTkn = 1'b0; ResTarget = 32'h900; ResPCPlus4 = 32'h84;
      run_cycle("gs");
    end
    idle();
    PredValid = 1'b1; PredPC = 32'h80;
    #1;
    push("gs PredIdx_g literal", 32'h25); chk(32'(PredIdx_g));
    push("gs PredIdx literal",   32'h20); chk(32'(PredIdx_a));

    // Asynchronous reset while a mispredict pulse is live
    idle();
    PredValid = 1'b1; PredPC = 32'h40;
    ResValid = 1'b1; BranchEn = 1'b1; funct3 = 3'b001; z = 1'b0; ResIdx = 6'd16; ResPredTkn = 1'b0;
    ResTarget = 32'h500; ResPCPlus4 = 32'h44;
    run_cycle("pre-rst");
    push("pre-rst Mispredict literal", 32'h1); chk(32'(Mispredict_a));
    push("pre-rst PredTaken literal",  32'h1); chk(32'(PredTaken_a));
    ResValid = 1'b0; BranchEn = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    push("midrst Mispredict",   32'h0);  chk(32'(Mispredict_a));
    push("midrst Mispredict_g", 32'h0);  chk(32'(Mispredict_g));
    push("midrst RedirectPC",   32'h0);  chk(RedirectPC_a);
    push("midrst BrCount",      32'h0);  chk(32'(BrCount_a));
    push("midrst MissCount",    32'h0);  chk(32'(MissCount_a));
    push("midrst PredTaken",    32'h0);  chk(32'(PredTaken_a));
    push("midrst PredIdx_g",    32'h10); chk(32'(PredIdx_g));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_cycle("post-rst");

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
